steer_input_multi: RTL and testbench
====================================

STEER_INPUT_MULTI -- requirements
Module: steer_input_multi

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of steering channels (legal 1..4).
REQ-002 Parameter DIV_WIDTH, default 23, sample-tick divider width; tick period is 2^DIV_WIDTH CLK cycles.
REQ-003 Parameter DEBOUNCE_SAMPLES, default 3, consecutive equal ticks required to change a debounced level (legal 2..8).
REQ-004 CLK  in  1  single system clock; all state on its rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 opCode  in  4  [3:2] player index, [1:0] field: 00 turn count, 01 dx, 10 dy, 11 button status.
REQ-007 leftButton  in  NUM_PLAYERS  raw asynchronous left button per player.
REQ-008 rightButton  in  NUM_PLAYERS  raw asynchronous right button per player.
REQ-009 writeEnable  in  1  write data to the field selected by opCode.
REQ-010 data  in  32  write data.
REQ-011 delta  out  32  read data for the field selected by opCode.

Function
REQ-012 Divider counts CLK cycles; tick asserted for one cycle when counter is all-ones; counter wraps to 0.
REQ-013 Each button passes a 2-flop synchroniser, then is sampled into a DEBOUNCE_SAMPLES-deep shift register on tick only.
REQ-014 Debounced level goes 1 when all shift stages are 1, 0 when all are 0, otherwise holds.
REQ-015 Press event = debounced level 0->1; exactly one event per press regardless of hold duration.
REQ-016 Per-player heading states: STOP, RIGHT, DOWN, LEFT, UP.
REQ-017 Left event: RIGHT->UP, UP->LEFT, LEFT->DOWN, DOWN->RIGHT; right event: RIGHT->DOWN, DOWN->LEFT, LEFT->UP, UP->RIGHT.
REQ-018 STOP ignores all events; an ignored event does not increment the turn count.
REQ-019 Left and right events for one player in the same tick cancel: no turn, no count.
REQ-020 A turn updates heading in the cycle of the tick completing debounce; new heading visible on delta the next cycle.
REQ-021 dx read: 1 for RIGHT, 32'hFFFFFFFF for LEFT, 0 otherwise; dy read: 1 for DOWN, 32'hFFFFFFFF for UP, 0 otherwise.
REQ-022 Write dx: 1 -> RIGHT, 32'hFFFFFFFF -> LEFT, 0 -> STOP; write dy: 1 -> DOWN, 32'hFFFFFFFF -> UP, 0 -> STOP; any other value ignored.
REQ-023 Turn count: 8-bit per player, increments per applied turn, wraps 255->0; read zero-extended; any write to field 00 clears it.
REQ-024 Status read: bit0 debounced left, bit1 debounced right of selected player, other bits 0; writes to field 11 ignored.
REQ-025 Write and turn for the same player in the same cycle: write wins, turn dropped, count unchanged (unless write clears it).
REQ-026 Player index >= NUM_PLAYERS: reads return 0, writes ignored.
REQ-027 delta is combinational from opCode and state; zero-cycle read latency.

Reset
REQ-028 RST_N low asynchronously clears divider, synchronisers, shift registers, debounced levels, counts; all headings STOP; delta then reads 0 for every field.
REQ-029 Reset mid-press: after release, a still-held button yields an event only after DEBOUNCE_SAMPLES ticks of 1.

Structure
REQ-030 Shared package input_pkg holds field opcodes, heading encoding, and delta constants (0, 1, 32'hFFFFFFFF).
REQ-031 One sub-module button_debounce (synchroniser, shift register, level, rise pulse), instantiated 2*NUM_PLAYERS times.

Verification (DIV_WIDTH=2, DEBOUNCE_SAMPLES=3, NUM_PLAYERS=2)
REQ-032 Write dx=1 to player 0, hold left0 for 20 cycles -> heading UP after 3rd tick, dy reads 32'hFFFFFFFF, count reads 1, no further turn while held.
REQ-033 Player 1 heading DOWN, left1 and right1 rise together -> heading stays DOWN, count 0.
REQ-034 left0 glitch high for 2 ticks then low -> no turn, status bit0 never 1.
REQ-035 Turn tick coincides with write dy=32'hFFFFFFFF to same player -> heading UP, count unchanged.
REQ-036 256 turns on player 0 -> count reads 0; write field 00 -> count 0; opCode player 2 or 3 -> delta 0.
REQ-037 RST_N low mid-press with heading LEFT -> dx reads 0 immediately; after release, held button turns only after 3 ticks, heading stays STOP until written.

Source files
------------

// File: rtl/input_pkg.sv
// Shared encodings for the steering input block: field opcodes, heading states,
// read-back constants and the heading rotation helpers.
package input_pkg;

    typedef enum logic [2:0] {
        HD_STOP  = 3'd0,
        HD_RIGHT = 3'd1,
        HD_DOWN  = 3'd2,
        HD_LEFT  = 3'd3,
        HD_UP    = 3'd4
    } heading_t;

    localparam logic [1:0] FLD_COUNT  = 2'b00;
    localparam logic [1:0] FLD_DX     = 2'b01;
    localparam logic [1:0] FLD_DY     = 2'b10;
    localparam logic [1:0] FLD_STATUS = 2'b11;

    localparam logic [31:0] DELTA_ZERO = 32'h0000_0000;
    localparam logic [31:0] DELTA_POS  = 32'h0000_0001;
    localparam logic [31:0] DELTA_NEG  = 32'hFFFF_FFFF;

    // Counter-clockwise quarter turn; STOP is a fixed point.
    function automatic heading_t turn_left(input heading_t h);
        case (h)
            HD_RIGHT: return HD_UP;
            HD_UP:    return HD_LEFT;
            HD_LEFT:  return HD_DOWN;
            HD_DOWN:  return HD_RIGHT;
            default:  return HD_STOP;
        endcase
    endfunction

    function automatic heading_t turn_right(input heading_t h);
        case (h)
            HD_RIGHT: return HD_DOWN;
            HD_DOWN:  return HD_LEFT;
            HD_LEFT:  return HD_UP;
            HD_UP:    return HD_RIGHT;
            default:  return HD_STOP;
        endcase
    endfunction

    function automatic logic [31:0] head_dx(input heading_t h);
        case (h)
            HD_RIGHT: return DELTA_POS;
            HD_LEFT:  return DELTA_NEG;
            default:  return DELTA_ZERO;
        endcase
    endfunction

    function automatic logic [31:0] head_dy(input heading_t h);
        case (h)
            HD_DOWN: return DELTA_POS;
            HD_UP:   return DELTA_NEG;
            default: return DELTA_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchroniser, tick-sampled shift register, hysteretic
// debounced level and a single-cycle rise pulse coincident with the completing tick.
module button_debounce #(
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    logic [1:0]                  r_sync;
    logic [DEBOUNCE_SAMPLES-1:0] r_shift;
    logic [DEBOUNCE_SAMPLES-1:0] w_shift_nxt;
    logic                        r_level;
    logic                        w_level_nxt;

    assign w_shift_nxt = {r_shift[DEBOUNCE_SAMPLES-2:0], r_sync[1]};

    always_comb begin
        w_level_nxt = r_level;
        if (&w_shift_nxt)
            w_level_nxt = 1'b1;
        else if (~|w_shift_nxt)
            w_level_nxt = 1'b0;
    end

    // Rise is flagged on the tick itself so the turn lands on the same edge.
    assign o_rise  = i_tick & w_level_nxt & ~r_level;
    assign o_level = r_level;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync  <= '0;
            r_shift <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (i_tick) begin
                r_shift <= w_shift_nxt;
                r_level <= w_level_nxt;
            end
        end
    end

endmodule

// File: rtl/steer_input_multi.sv
// Multi-player steering input: debounced left/right buttons rotate a per-player
// heading; headings, turn counts and button status are read/written via opCode.
module steer_input_multi
    import input_pkg::*;
#(
    parameter int NUM_PLAYERS      = 2,
    parameter int DIV_WIDTH        = 23,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [3:0]             opCode,
    input  logic [NUM_PLAYERS-1:0] leftButton,
    input  logic [NUM_PLAYERS-1:0] rightButton,
    input  logic                   writeEnable,
    input  logic [31:0]            data,
    output logic [31:0]            delta
);

    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_tick;

    assign w_tick = &r_div;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_div <= '0;
        else
            r_div <= r_div + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end

    // Read-side views padded to the full 2-bit player space; absent players read 0.
    heading_t   w_rd_head [4];
    logic [7:0] w_rd_cnt  [4];
    logic [1:0] w_rd_sts  [4];

    for (genvar p = 0; p < 4; p++) begin : g_pl
        if (p < NUM_PLAYERS) begin : g_on
            logic     w_l_lvl, w_l_rise, w_r_lvl, w_r_rise;
            logic     w_wr;
            heading_t r_head;
            logic [7:0] r_cnt;

            button_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_left (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .i_tick  (w_tick),
                .i_raw   (leftButton[p]),
                .o_level (w_l_lvl),
                .o_rise  (w_l_rise)
            );

            button_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_right (
                .CLK     (CLK),
                .RST_N   (RST_N),
                .i_tick  (w_tick),
                .i_raw   (rightButton[p]),
                .o_level (w_r_lvl),
                .o_rise  (w_r_rise)
            );

            assign w_wr = writeEnable && (opCode[3:2] == 2'(p));

            // A host write to this player pre-empts any turn on the same edge.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_head <= HD_STOP;
                    r_cnt  <= '0;
                end else if (w_wr) begin
                    case (opCode[1:0])
                        FLD_COUNT: r_cnt <= '0;
                        FLD_DX: begin
                            if (data == DELTA_POS)       r_head <= HD_RIGHT;
                            else if (data == DELTA_NEG)  r_head <= HD_LEFT;
                            else if (data == DELTA_ZERO) r_head <= HD_STOP;
                        end
                        FLD_DY: begin
                            if (data == DELTA_POS)       r_head <= HD_DOWN;
                            else if (data == DELTA_NEG)  r_head <= HD_UP;
                            else if (data == DELTA_ZERO) r_head <= HD_STOP;
                        end
                        default: ;
                    endcase
                end else if ((w_l_rise ^ w_r_rise) && r_head != HD_STOP) begin
                    r_head <= w_l_rise ? turn_left(r_head) : turn_right(r_head);
                    r_cnt  <= r_cnt + 8'd1;
                end
            end

            assign w_rd_head[p] = r_head;
            assign w_rd_cnt[p]  = r_cnt;
            assign w_rd_sts[p]  = {w_r_lvl, w_l_lvl};
        end else begin : g_off
            assign w_rd_head[p] = HD_STOP;
            assign w_rd_cnt[p]  = 8'd0;
            assign w_rd_sts[p]  = 2'b00;
        end
    end

    always_comb begin
        delta = DELTA_ZERO;
        case (opCode[1:0])
            FLD_COUNT:  delta = {24'd0, w_rd_cnt[opCode[3:2]]};
            FLD_DX:     delta = head_dx(w_rd_head[opCode[3:2]]);
            FLD_DY:     delta = head_dy(w_rd_head[opCode[3:2]]);
            FLD_STATUS: delta = {30'd0, w_rd_sts[opCode[3:2]]};
            default:    delta = DELTA_ZERO;
        endcase
    end

endmodule

// File: tb/tb_steer_input_multi.sv
// Randomised and directed bench for steer_input_multi against a compass-arithmetic model.
module tb_steer_input_multi;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  opCode;
    logic [1:0]  leftButton;
    logic [1:0]  rightButton;
    logic        writeEnable;
    logic [31:0] data;
    logic [31:0] delta;

    int n_tests = 0;
    int n_fail  = 0;

    steer_input_multi #(
        .NUM_PLAYERS      (2),
        .DIV_WIDTH        (2),
        .DEBOUNCE_SAMPLES (3)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .opCode      (opCode),
        .leftButton  (leftButton),
        .rightButton (rightButton),
        .writeEnable (writeEnable),
        .data        (data),
        .delta       (delta)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    // Reference model. Heading is a compass index: 0 right, 1 down, 2 left, 3 up
    // (clockwise), -1 stopped. Button index b: 0 left, 1 right.
    int m_div;
    bit m_s0  [2][2];
    bit m_s1  [2][2];
    bit m_h   [2][2][3];
    bit m_lvl [2][2];
    int m_dir [2];
    int m_cnt [2];

    task automatic model_reset();
        m_div = 0;
        for (int p = 0; p < 2; p++) begin
            m_dir[p] = -1;
            m_cnt[p] = 0;
            for (int b = 0; b < 2; b++) begin
                m_s0[p][b] = 0; m_s1[p][b] = 0; m_lvl[p][b] = 0;
                for (int k = 0; k < 3; k++) m_h[p][b][k] = 0;
            end
        end
    endtask

    task automatic model_edge();
        bit tick;
        bit rise [2][2];
        bit raw;
        tick = (m_div == 3);
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 2; b++) begin
                raw = b ? rightButton[p] : leftButton[p];
                rise[p][b] = 0;
                if (tick) begin
                    m_h[p][b][2] = m_h[p][b][1];
                    m_h[p][b][1] = m_h[p][b][0];
                    m_h[p][b][0] = m_s1[p][b];
                    if (m_h[p][b][0] && m_h[p][b][1] && m_h[p][b][2]) begin
                        rise[p][b] = !m_lvl[p][b];
                        m_lvl[p][b] = 1;
                    end else if (!m_h[p][b][0] && !m_h[p][b][1] && !m_h[p][b][2]) begin
                        m_lvl[p][b] = 0;
                    end
                end
                m_s1[p][b] = m_s0[p][b];
                m_s0[p][b] = raw;
            end
        end
        m_div = (m_div + 1) % 4;
        for (int p = 0; p < 2; p++) begin
            if (writeEnable && opCode[3:2] == p[1:0]) begin
                case (opCode[1:0])
                    2'b00: m_cnt[p] = 0;
                    2'b01: if (data == 32'd1) m_dir[p] = 0;
                           else if (data == 32'hFFFF_FFFF) m_dir[p] = 2;
                           else if (data == 32'd0) m_dir[p] = -1;
                    2'b10: if (data == 32'd1) m_dir[p] = 1;
                           else if (data == 32'hFFFF_FFFF) m_dir[p] = 3;
                           else if (data == 32'd0) m_dir[p] = -1;
                    default: ;
                endcase
            end else if (rise[p][0] != rise[p][1] && m_dir[p] >= 0) begin
                m_dir[p] = rise[p][1] ? (m_dir[p] + 1) % 4 : (m_dir[p] + 3) % 4;
                m_cnt[p] = (m_cnt[p] + 1) % 256;
            end
        end
    endtask

    function automatic logic [31:0] exp_delta(input logic [3:0] op);
        int p;
        p = int'(op[3:2]);
        if (p >= 2) return 32'd0;
        case (op[1:0])
            2'b00: return 32'(m_cnt[p]);
            2'b01: return (m_dir[p] == 0) ? 32'd1 : (m_dir[p] == 2) ? 32'hFFFF_FFFF : 32'd0;
            2'b10: return (m_dir[p] == 1) ? 32'd1 : (m_dir[p] == 3) ? 32'hFFFF_FFFF : 32'd0;
            default: return {30'd0, m_lvl[p][1], m_lvl[p][0]};
        endcase
    endfunction

    // True when the coming edge is a tick on which this button's debounce completes.
    function automatic bit will_rise(input int p, input int b);
        return (m_div == 3) && m_s1[p][b] && m_h[p][b][0] && m_h[p][b][1] && !m_lvl[p][b];
    endfunction

    task automatic cyc();
        @(posedge CLK);
        if (RST_N) model_edge();
        @(negedge CLK);
    endtask

    task automatic wr(input logic [3:0] op, input logic [31:0] d);
        opCode = op; data = d; writeEnable = 1'b1;
        cyc();
        writeEnable = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; opCode = 4'h0; leftButton = '0; rightButton = '0;
        writeEnable = 1'b0; data = '0;
        model_reset();
        repeat (3) cyc();
        for (int i = 0; i < 16; i++) begin
            opCode = 4'(i); #1;
            n_tests++;
            if (delta !== 32'd0) begin
                n_fail++; $display("FAIL reset_read op=%0h got=%h exp=00000000", opCode, delta);
            end
        end
        RST_N = 1'b1;
        cyc();
    endtask

    task automatic test_turn_hold();
        wr(4'b0001, 32'd1);
        leftButton[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            opCode = 4'b0010; #1;
            n_tests++;
            if (delta !== exp_delta(opCode)) begin
                n_fail++; $display("FAIL hold_dy cyc=%0d got=%h exp=%h", c, delta, exp_delta(opCode));
            end
        end
        opCode = 4'b0010; #1;
        n_tests++;
        if (delta !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL hold_up got=%h exp=ffffffff", delta);
        end
        opCode = 4'b0000; #1;
        n_tests++;
        if (delta !== 32'd1) begin
            n_fail++; $display("FAIL hold_count got=%h exp=00000001", delta);
        end
        leftButton[0] = 1'b0;
        repeat (24) cyc();
    endtask

    task automatic test_cancel();
        wr(4'b0110, 32'd1);
        wr(4'b0100, 32'd0);
        leftButton[1] = 1'b1; rightButton[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            opCode = (c % 2) ? 4'b0111 : 4'b0110; #1;
            n_tests++;
            if (delta !== exp_delta(opCode)) begin
                n_fail++; $display("FAIL cancel_trace op=%0h got=%h exp=%h", opCode, delta, exp_delta(opCode));
            end
        end
        opCode = 4'b0110; #1;
        n_tests++;
        if (delta !== 32'd1) begin
            n_fail++; $display("FAIL cancel_dy got=%h exp=00000001", delta);
        end
        opCode = 4'b0100; #1;
        n_tests++;
        if (delta !== 32'd0) begin
            n_fail++; $display("FAIL cancel_count got=%h exp=00000000", delta);
        end
        opCode = 4'b0111; #1;
        n_tests++;
        if (delta !== 32'd3) begin
            n_fail++; $display("FAIL cancel_status got=%h exp=00000003", delta);
        end
        leftButton[1] = 1'b0; rightButton[1] = 1'b0;
        repeat (24) cyc();
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 24; c++) begin
            leftButton[0] = (c < 8);
            cyc();
            opCode = 4'b0011; #1;
            n_tests++;
            if (delta[0] !== 1'b0 || delta !== exp_delta(opCode)) begin
                n_fail++; $display("FAIL glitch_status cyc=%0d got=%h exp=%h", c, delta, exp_delta(opCode));
            end
        end
        opCode = 4'b0010; #1;
        n_tests++;
        if (delta !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL glitch_dy got=%h exp=ffffffff", delta);
        end
        opCode = 4'b0000; #1;
        n_tests++;
        if (delta !== 32'd1) begin
            n_fail++; $display("FAIL glitch_count got=%h exp=00000001", delta);
        end
    endtask

    task automatic test_write_vs_turn();
        bit hit;
        hit = 0;
        wr(4'b0001, 32'd1);
        wr(4'b0000, 32'd0);
        rightButton[0] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (!hit && will_rise(0, 1)) begin
                hit = 1;
                wr(4'b0010, 32'hFFFF_FFFF);
            end else begin
                cyc();
            end
        end
        n_tests++;
        if (!hit) begin
            n_fail++; $display("FAIL wvt_coincide got=0 exp=1");
        end
        opCode = 4'b0010; #1;
        n_tests++;
        if (delta !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wvt_dy got=%h exp=ffffffff", delta);
        end
        opCode = 4'b0000; #1;
        n_tests++;
        if (delta !== 32'd0) begin
            n_fail++; $display("FAIL wvt_count got=%h exp=00000000", delta);
        end
        rightButton[0] = 1'b0;
        repeat (24) cyc();
    endtask

    task automatic test_wrap();
        int b;
        wr(4'b0001, 32'd1);
        wr(4'b0000, 32'd0);
        for (int t = 0; t < 256; t++) begin
            b = int'($urandom_range(0, 1));
            if (b == 1) rightButton[0] = 1'b1; else leftButton[0] = 1'b1;
            repeat (16) cyc();
            leftButton[0] = 1'b0; rightButton[0] = 1'b0;
            repeat (16) cyc();
            opCode = 4'b0000; #1;
            n_tests++;
            if (delta !== exp_delta(opCode)) begin
                n_fail++; $display("FAIL wrap_trace turn=%0d got=%h exp=%h", t, delta, exp_delta(opCode));
            end
        end
        opCode = 4'b0000; #1;
        n_tests++;
        if (delta !== 32'd0) begin
            n_fail++; $display("FAIL wrap_count got=%h exp=00000000", delta);
        end
        for (int i = 1; i < 3; i++) begin
            opCode = 4'(i); #1;
            n_tests++;
            if (delta !== exp_delta(opCode)) begin
                n_fail++; $display("FAIL wrap_head op=%0h got=%h exp=%h", opCode, delta, exp_delta(opCode));
            end
        end
        leftButton[0] = 1'b1;
        repeat (16) cyc();
        leftButton[0] = 1'b0;
        repeat (16) cyc();
        wr(4'b0000, $urandom);
        opCode = 4'b0000; #1;
        n_tests++;
        if (delta !== 32'd0) begin
            n_fail++; $display("FAIL clear_count got=%h exp=00000000", delta);
        end
        wr(4'b1001, 32'd1);
        wr(4'b1110, 32'hFFFF_FFFF);
        for (int i = 8; i < 16; i++) begin
            opCode = 4'(i); #1;
            n_tests++;
            if (delta !== 32'd0) begin
                n_fail++; $display("FAIL bad_player op=%0h got=%h exp=00000000", opCode, delta);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 11) == 0) leftButton[$urandom_range(0, 1)]  ^= 1'b1;
            if ($urandom_range(0, 11) == 0) rightButton[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0: d = 32'd0;
                    1: d = 32'd1;
                    2: d = 32'hFFFF_FFFF;
                    default: d = $urandom;
                endcase
                wr(4'($urandom_range(0, 15)), d);
            end else begin
                cyc();
            end
            opCode = 4'($urandom_range(0, 15)); #1;
            n_tests++;
            if (delta !== exp_delta(opCode)) begin
                n_fail++; $display("FAIL random cyc=%0d op=%0h got=%h exp=%h", c, opCode, delta, exp_delta(opCode));
            end
        end
        leftButton = '0; rightButton = '0;
        repeat (24) cyc();
    endtask

    task automatic test_reset_mid_press();
        wr(4'b0001, 32'd1);
        leftButton[0] = 1'b1;
        repeat (20) cyc();
        wr(4'b0001, 32'hFFFF_FFFF);
        opCode = 4'b0001; #1;
        n_tests++;
        if (delta !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL pre_reset_dx got=%h exp=ffffffff", delta);
        end
        #10 RST_N = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (delta !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_dx got=%h exp=00000000", delta);
        end
        cyc(); cyc();
        RST_N = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            opCode = 4'b0011; #1;
            n_tests++;
            if (delta !== exp_delta(opCode)) begin
                n_fail++; $display("FAIL post_reset_status cyc=%0d got=%h exp=%h", c, delta, exp_delta(opCode));
            end
            if (c == 11 || c == 13) begin
                n_tests++;
                if (delta !== ((c == 13) ? 32'd1 : 32'd0)) begin
                    n_fail++; $display("FAIL post_reset_debounce cyc=%0d got=%h exp=%0d", c, delta, (c == 13));
                end
            end
            opCode = 4'b0001; #1;
            n_tests++;
            if (delta !== 32'd0) begin
                n_fail++; $display("FAIL post_reset_stop cyc=%0d got=%h exp=00000000", c, delta);
            end
        end
        opCode = 4'b0000; #1;
        n_tests++;
        if (delta !== 32'd0) begin
            n_fail++; $display("FAIL post_reset_count got=%h exp=00000000", delta);
        end
        wr(4'b0001, 32'd1);
        opCode = 4'b0001; #1;
        n_tests++;
        if (delta !== 32'd1) begin
            n_fail++; $display("FAIL post_reset_write got=%h exp=00000001", delta);
        end
        leftButton[0] = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        test_reset();
        test_turn_hold();
        test_cancel();
        test_glitch();
        test_write_vs_turn();
        test_wrap();
        test_random();
        test_reset_mid_press();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
